// File: rtl/booth_r4_pkg.sv
// Shared types and the Booth digit decoder for the radix-4 multiplier family.
// Used by both the sequential controller and the parallel array.
package booth_r4_pkg;

    typedef enum logic [2:0] {
        OP_ZERO = 3'd0,
        OP_POS1 = 3'd1,
        OP_POS2 = 3'd2,
        OP_NEG1 = 3'd3,
        OP_NEG2 = 3'd4
    } booth_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_e;

    // The digit is {Y[2i+1], Y[2i], Y[2i-1]}.
    function automatic booth_op_e booth_decode(input logic [2:0] digit);
        booth_op_e op;
        case (digit)
            3'b000, 3'b111: op = OP_ZERO;
            3'b001, 3'b010: op = OP_POS1;
            3'b011:         op = OP_POS2;
            3'b100:         op = OP_NEG2;
            3'b101, 3'b110: op = OP_NEG1;
            default:        op = OP_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Combinational radix-4 Booth partial-product generator.
// The output is two bits wider than X, so that -2 * (-2^(WIDTH-1)) is exact.
module booth_r4_pp_gen
    import booth_r4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]        x_i,
    input  logic [2:0]              digit_i,
    output logic signed [WIDTH+1:0] pp_o
);

    logic signed [WIDTH+1:0] x_ext_s;

    assign x_ext_s = {{2{x_i[WIDTH-1]}}, x_i};

    // Select the multiple of X that the digit calls for.
    always_comb begin
        pp_o = '0;
        case (booth_decode(digit_i))
            OP_ZERO: pp_o = '0;
            OP_POS1: pp_o = x_ext_s;
            OP_POS2: pp_o = x_ext_s <<< 1;
            OP_NEG1: pp_o = -x_ext_s;
            OP_NEG2: pp_o = -(x_ext_s <<< 1);
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller. It retires one digit per clock
// into a 2*WIDTH accumulator, with valid/ready handshakes on the input and the output.
module booth_r4_seq_ctrl
    import booth_r4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   X_i,
    input  logic [WIDTH-1:0]   Y_i,
    input  logic               abort_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] Output_o,
    output logic               busy_o
);

    localparam int NDIG = WIDTH / 2;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW   = 2 * WIDTH;

    ctrl_state_e             state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        x_q, x_d;
    logic [WIDTH:0]          y_q, y_d;
    logic [PW-1:0]           acc_q, acc_d;
    logic [PW-1:0]           out_q, out_d;
    logic signed [WIDTH+1:0] pp_s;
    logic [PW-1:0]           pp_ext_s;
    logic [PW-1:0]           pp_sh_s;
    logic [PW-1:0]           sum_s;
    logic                    last_s;

    // y_q shifts right by two each digit, so the current digit is always y_q[2:0].
    booth_r4_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .x_i     (x_q),
        .digit_i (y_q[2:0]),
        .pp_o    (pp_s)
    );

    assign pp_ext_s = {{(PW-WIDTH-2){pp_s[WIDTH+1]}}, pp_s};
    assign pp_sh_s  = pp_ext_s << {cnt_q, 1'b0};
    assign sum_s    = acc_q + pp_sh_s;
    assign last_s   = (cnt_q == CW'(NDIG - 1));

    // Next-state logic; abort_i outranks both digit retirement and the output handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    x_d     = X_i;
                    y_d     = {Y_i, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = sum_s;
                    y_d   = {{2{y_q[WIDTH]}}, y_q[WIDTH:2]};
                    if (last_s) begin
                        out_d   = sum_s;
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = ST_CALC;
                    end
                end
            end
            ST_DONE: begin
                if (abort_i || out_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign Output_o    = out_q;

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Self-checking bench for booth_r4_seq_ctrl: directed corner cases, then a randomized
// stream scored against plain signed multiplication.
module tb_booth_r4_seq_ctrl;

    localparam int W    = 8;
    localparam int PW   = 2 * W;
    localparam int NDIG = W / 2;
    localparam int NRND = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x_in;
    logic [W-1:0]  y_in;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] prod;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [PW-1:0] exp_q[$];

    booth_r4_seq_ctrl #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .X_i         (x_in),
        .Y_i         (y_in),
        .abort_i     (abort),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .Output_o    (prod),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [PW-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    // Leaves the bench at the negedge inside the first CALC cycle.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_eq("in_ready timeout", 64'd0, 64'd1);
        in_valid = 1'b1;
        x_in     = x;
        y_in     = y;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts cycles from the handshake cycle to the first cycle with out_valid high.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [PW-1:0] exp);
        int lat;
        out_ready = 1'b1;
        start_op(x, y);
        check_eq({tag, " busy"}, 64'(busy), 64'd1);
        check_eq({tag, " in_ready calc"}, 64'(in_ready), 64'd0);
        wait_valid(lat);
        check_eq({tag, " latency"}, 64'(lat), 64'(NDIG + 1));
        check_eq({tag, " product"}, 64'(prod), 64'(exp));
        @(negedge clk);
        check_eq({tag, " in_ready after"}, 64'(in_ready), 64'd1);
        check_eq({tag, " valid after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int sent;
        int got;
        int cyc;
        logic r;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic [PW-1:0] e;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x_in      = '0;
        y_in      = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #12;
        check_eq("reset in_ready", 64'(in_ready), 64'd1);
        check_eq("reset out_valid", 64'(out_valid), 64'd0);
        check_eq("reset output", 64'(prod), 64'd0);
        check_eq("reset busy", 64'(busy), 64'd0);
        #1 rst_n = 1'b1;

        run_op("7x3", 8'd7, 8'd3, 16'h0015);
        run_op("m128xm128", 8'h80, 8'h80, 16'h4000);
        run_op("m128x127", 8'h80, 8'h7F, 16'hC080);
        run_op("m1xm1", 8'hFF, 8'hFF, 16'h0001);
        run_op("127x127", 8'h7F, 8'h7F, 16'h3F01);
        run_op("m128x2", 8'h80, 8'h02, 16'hFF00);

        // Back-pressure: product must hold steady while the consumer stalls.
        out_ready = 1'b0;
        start_op(8'hFB, 8'd6);
        wait_valid(lat);
        check_eq("bp latency", 64'(lat), 64'(NDIG + 1));
        for (int i = 0; i < 10; i++) begin
            check_eq("bp valid", 64'(out_valid), 64'd1);
            check_eq("bp product", 64'(prod), 64'hFFE2);
            check_eq("bp in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp valid drop", 64'(out_valid), 64'd0);
        check_eq("bp in_ready back", 64'(in_ready), 64'd1);

        // Abort in the second CALC cycle discards the operation.
        start_op(8'd9, 8'd9);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort in_ready", 64'(in_ready), 64'd1);
        check_eq("abort busy", 64'(busy), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check_eq("abort no valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        run_op("2xm3", 8'd2, 8'hFD, 16'hFFFA);

        // Asynchronous reset mid-CALC, off the clock edge.
        start_op(8'd10, 8'd10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst valid", 64'(out_valid), 64'd0);
        check_eq("arst output", 64'(prod), 64'd0);
        check_eq("arst in_ready", 64'(in_ready), 64'd1);
        check_eq("arst busy", 64'(busy), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("arst no valid", 64'(out_valid), 64'd0);
        end

        // Randomized stream with gaps on both sides.
        sent     = 0;
        got      = 0;
        cyc      = 0;
        in_valid = 1'b0;
        while (got < NRND && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            r = ($urandom_range(0, 3) != 0);
            out_ready = r;
            if (out_valid && r) begin
                if (exp_q.size() == 0) begin
                    check_eq("rnd spurious output", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rnd product", 64'(prod), 64'(e));
                end
                got++;
            end
            if (!(in_valid && !in_ready)) begin
                if (sent < NRND && $urandom_range(0, 2) != 0) begin
                    rx = W'($urandom);
                    ry = W'($urandom);
                    if ($urandom_range(0, 15) == 0) rx = 8'h80;
                    if ($urandom_range(0, 15) == 0) ry = 8'h80;
                    in_valid = 1'b1;
                    x_in     = rx;
                    y_in     = ry;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_mul(x_in, y_in));
                sent++;
            end
        end
        in_valid = 1'b0;
        check_eq("rnd all received", 64'(got), 64'(NRND));
        check_eq("rnd queue empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
